// File: rtl/mem_loader.sv
// Streams len bytes from a valid/ready source into a 256x8 memory starting at base.
// Defining MEM_LOADER_VERIFY_EN adds a readback pass that sets err on a checksum mismatch.
module mem_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] base,
  input  logic [7:0] len,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] sum,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
`ifdef MEM_LOADER_VERIFY_EN
  localparam logic [1:0] S_VERIFY = 2'd2;
`endif
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic       accept;
  logic [8:0] len_full;

  // Handshake: a byte moves on a rising edge where s_valid && s_ready; s_ready
  // depends only on state, and the memory write happens on that same edge.
  assign s_ready   = (state_q == S_LOAD);
  assign accept    = s_ready & s_valid;
  assign mem_we    = accept;
  assign mem_addr  = ptr_q;
  assign mem_wdata = s_data;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign dbg_state = state_q;
  assign len_full  = (len == 8'd0) ? 9'd256 : {1'b0, len};

`ifdef MEM_LOADER_VERIFY_EN
  logic [7:0] base_q, base_d;
  logic [8:0] len_q, len_d;
  logic [7:0] vsum_q, vsum_d;
  logic       err_q, err_d;
  logic [7:0] vsum_next;

  assign vsum_next = vsum_q + mem_rdata;
  assign err       = err_q;
`else
  logic unused_rdata;

  assign unused_rdata = ^mem_rdata;
  assign err          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
`ifdef MEM_LOADER_VERIFY_EN
    base_d  = base_q;
    len_d   = len_q;
    vsum_d  = vsum_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = base;
          cnt_d   = len_full;
          sum_d   = 8'd0;
`ifdef MEM_LOADER_VERIFY_EN
          base_d  = base;
          len_d   = len_full;
          vsum_d  = 8'd0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (accept) begin
          ptr_d = ptr_q + 8'd1;
          sum_d = sum_q + s_data;
          cnt_d = cnt_q - 9'd1;
        end
        // Abort wins over completion, but the byte accepted this cycle is still written.
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept && (cnt_q == 9'd1)) begin
`ifdef MEM_LOADER_VERIFY_EN
          state_d = S_VERIFY;
          ptr_d   = base_q;
          cnt_d   = len_q;
          vsum_d  = 8'd0;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          vsum_d = vsum_next;
          ptr_d  = ptr_q + 8'd1;
          cnt_d  = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            err_d   = (vsum_next != sum_q);
            state_d = S_DONE;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 8'd0;
      cnt_q   <= 9'd0;
      sum_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

`ifdef MEM_LOADER_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= 8'd0;
      len_q  <= 9'd0;
      vsum_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      vsum_q <= vsum_d;
      err_q  <= err_d;
    end
  end
`endif

endmodule
